// File: rtl/uart_receiver_pkg.sv
// Shared GPS serial definitions: frame width, default clock and baud, and receiver state codes.
package uart_receiver_pkg;

    localparam int unsigned B         = 8;
    localparam int unsigned ClockFreq = 100_000_000;
    localparam int unsigned BaudRate  = 9600;

    typedef logic [2:0] state_t;

    localparam state_t S_Idle  = 3'd0;
    localparam state_t S_Start = 3'd1;
    localparam state_t S_Data  = 3'd2;
    localparam state_t S_Stop  = 3'd3;
    localparam state_t S_Wait  = 3'd4;

    // Five ASCII characters, for waveform viewing only.
    typedef logic [39:0] state_str_t;

    function automatic state_str_t state_name(input state_t s);
        case (s)
            S_Idle:  return "IDLE ";
            S_Start: return "START";
            S_Data:  return "DATA ";
            S_Stop:  return "STOP ";
            S_Wait:  return "WAIT ";
            default: return "?????";
        endcase
    endfunction

endpackage

// File: rtl/uart_receiver_bit_timer.sv
// Bit-period counter: ticks when the count equals the terminal value, then restarts from zero.
module bit_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic [Width-1:0] terminal,
    output logic             tick
);

    logic [Width-1:0] cnt_q;

    assign tick = (cnt_q == terminal);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error strobe, break hold-off.
module uart_receiver #(
    parameter int unsigned B         = uart_receiver_pkg::B,
    parameter int unsigned ClockFreq = uart_receiver_pkg::ClockFreq,
    parameter int unsigned BaudRate  = uart_receiver_pkg::BaudRate
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         rx,
    output logic         load,
    output logic [B-1:0] data,
    output logic         frame_error
);
    import uart_receiver_pkg::*;

    localparam int unsigned Divisor = ClockFreq / BaudRate;
    localparam int unsigned Half    = Divisor / 2;
    localparam int unsigned CntW    = $clog2(Divisor);
    localparam int unsigned IdxW    = (B > 1) ? $clog2(B) : 1;

    localparam logic [CntW-1:0] HalfTc = CntW'(Half - 1);
    localparam logic [CntW-1:0] DivTc  = CntW'(Divisor - 1);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(B - 1);

    if (Divisor < 4) begin : g_bad_divisor
        $error("uart_receiver: ClockFreq / BaudRate must be at least 4");
    end

    logic         rx_meta_q, rx_s;
    state_t       state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [B-1:0] shreg_q, shreg_d;
    logic         stop_ok_q, stop_ok_d, stop_bad_q, stop_bad_d;
    logic         load_q, frame_error_q;
    logic [B-1:0] data_q;
    state_str_t   state_str_q;
    logic         tick;
    logic [CntW-1:0] terminal;

    assign terminal = (state_q == S_Start) ? HalfTc : DivTc;

    bit_timer #(
        .Width(CntW)
    ) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_d != state_q),
        .terminal(terminal),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        stop_ok_d  = 1'b0;
        stop_bad_d = 1'b0;
        case (state_q)
            S_Idle: if (!rx_s) state_d = S_Start;
            S_Start: begin
                if (tick) begin
                    if (!rx_s) begin
                        state_d = S_Data;
                        idx_d   = '0;
                    end else begin
                        state_d = S_Idle;
                    end
                end
            end
            S_Data: begin
                if (tick) begin
                    shreg_d[idx_q] = rx_s;
                    if (idx_q == LastIdx) state_d = S_Stop;
                    else                  idx_d   = idx_q + 1'b1;
                end
            end
            S_Stop: begin
                if (tick) begin
                    stop_ok_d  = rx_s;
                    stop_bad_d = !rx_s;
                    state_d    = rx_s ? S_Idle : S_Wait;
                end
            end
            // A held-low line (break) must rise before another start bit is accepted.
            S_Wait:  if (rx_s) state_d = S_Idle;
            default: state_d = S_Idle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q     <= 1'b1;
            rx_s          <= 1'b1;
            state_q       <= S_Idle;
            idx_q         <= '0;
            shreg_q       <= '0;
            stop_ok_q     <= 1'b0;
            stop_bad_q    <= 1'b0;
            load_q        <= 1'b0;
            frame_error_q <= 1'b0;
            data_q        <= '0;
            state_str_q   <= state_name(S_Idle);
        end else begin
            rx_meta_q     <= rx;
            rx_s          <= rx_meta_q;
            state_q       <= state_d;
            idx_q         <= idx_d;
            shreg_q       <= shreg_d;
            stop_ok_q     <= stop_ok_d;
            stop_bad_q    <= stop_bad_d;
            load_q        <= stop_ok_q;
            frame_error_q <= stop_bad_q;
            state_str_q   <= state_name(state_d);
            if (stop_ok_q) data_q <= shreg_q;
        end
    end

    assign load        = load_q;
    assign frame_error = frame_error_q;
    assign data        = data_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frame table, corner sequences, random frames.
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       load, frame_error;
    logic [7:0] data;

    always #5 clock = ~clock;

    uart_receiver #(
        .B        (8),
        .ClockFreq(100),
        .BaudRate (10)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .load       (load),
        .data       (data),
        .frame_error(frame_error)
    );

    typedef struct {
        bit         is_load;
        logic [7:0] value;
        int         at;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        bit         stop;
        int         px10;   // bit period in tenths of a clock
        int         low;    // extra cycles rx is held low after the frame
        int         gap;    // idle-high cycles after that
        bit         exp_load;
        logic [7:0] exp_data;
    } vec_t;

    ev_t  got_q[$];
    ev_t  exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] last_good = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && (load || frame_error)) begin
            check("exclusive strobe", {31'b0, load && frame_error}, 32'd0);
            got_q.push_back('{load, data, cyc});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        step(n);
    endtask

    // Drives the first nbits bits of an 8N1 frame; bit edges rounded to whole clocks.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int px10,
                              input int nbits, output int t0);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        t0 = cyc;
        for (int j = 0; j < nbits; j++) begin
            rx = bits[j];
            while (cyc < t0 + ((j + 1) * px10 + 5) / 10) step(1);
        end
    endtask

    // Reference: a good stop bit delivers the byte; a bad one flags and keeps the old byte.
    task automatic model_frame(input logic [7:0] b, input bit stop);
        if (stop) begin
            exp_q.push_back('{1'b1, b, 0});
            last_good = b;
        end else begin
            exp_q.push_back('{1'b0, last_good, 0});
        end
    endtask

    task automatic compare_events(input string tag);
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s ev%0d kind", tag, i), {31'b0, got_q[i].is_load},
                  {31'b0, exp_q[i].is_load});
            check($sformatf("%s ev%0d data", tag, i), {24'b0, got_q[i].value},
                  {24'b0, exp_q[i].value});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t vecs[6];
        int   t0, t_first;

        vecs[0] = '{8'h24, 1'b1, 100, 0,  0, 1'b1, 8'h24};
        vecs[1] = '{8'h47, 1'b1, 100, 0, 20, 1'b1, 8'h47};
        vecs[2] = '{8'h5A, 1'b0, 100, 30, 20, 1'b0, 8'h47};
        vecs[3] = '{8'h41, 1'b1, 100, 0, 20, 1'b1, 8'h41};
        vecs[4] = '{8'hFF, 1'b1, 104, 0,  0, 1'b1, 8'hFF};
        vecs[5] = '{8'h00, 1'b1, 104, 0, 20, 1'b1, 8'h00};

        step(3);
        check("reset load", {31'b0, load}, 32'd0);
        check("reset frame_error", {31'b0, frame_error}, 32'd0);
        check("reset data", {24'b0, data}, 32'd0);
        check("reset state", {29'b0, u_dut.state_q}, {29'b0, S_Idle});
        reset = 1'b1;
        while (cyc < 20) step(1);

        t_first = 0;
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].b, vecs[i].stop, vecs[i].px10, 10, t0);
            if (i == 0) t_first = t0;
            if (vecs[i].low > 0) begin
                rx = 1'b0;
                step(vecs[i].low / 2);
                check("break holds wait", {29'b0, u_dut.state_q}, {29'b0, S_Wait});
                step(vecs[i].low - vecs[i].low / 2);
            end
            idle(vecs[i].gap);
            exp_q.push_back('{vecs[i].exp_load, vecs[i].exp_data, 0});
        end
        idle(30);
        // Start edge -> rx_s low (2) -> S_Start entry (+1) -> Half + 9*Divisor + 1 = 96.
        if (got_q.size() >= 2) begin
            check("first load latency", got_q[0].at, t_first + 99);
            check("back-to-back spacing", got_q[1].at - got_q[0].at, 32'd100);
        end
        compare_events("table");

        rx = 1'b0;
        step(3);
        idle(40);
        check("glitch state", {29'b0, u_dut.state_q}, {29'b0, S_Idle});
        compare_events("glitch");
        last_good = 8'h00;

        for (int n = 0; n < 25; n++) begin
            logic [7:0] b;
            bit         stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop, $urandom_range(97, 103), 10, t0);
            model_frame(b, stop);
            idle(stop ? $urandom_range(0, 12) : $urandom_range(5, 15));
        end
        send_frame(8'hA5, 1'b1, 100, 10, t0);
        model_frame(8'hA5, 1'b1);
        idle(30);
        compare_events("random");

        send_frame(8'h3C, 1'b1, 100, 4, t0);
        #2;
        reset = 1'b0;
        rx    = 1'b1;
        #1;
        check("abort load", {31'b0, load}, 32'd0);
        check("abort frame_error", {31'b0, frame_error}, 32'd0);
        check("abort data", {24'b0, data}, 32'd0);
        step(3);
        reset = 1'b1;
        last_good = 8'h00;
        idle(10);
        send_frame(8'h0D, 1'b1, 100, 10, t0);
        model_frame(8'h0D, 1'b1);
        idle(30);
        compare_events("after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

- Serial front end of the GPS time path.
- Recovers 8N1 asynchronous bytes from the GPS module's TX line and presents each one as a one-cycle `load` strobe with `data`.
- Its `load`/`data` pair connects directly to the NMEA sentence parser downstream, which consumes one byte per strobe.
- Rejects start-bit glitches and flags framing errors without emitting a byte.

## Interface
- `B`, 8: data bits per frame, sent LSB first.
- `ClockFreq`, 100_000_000: `clock` frequency in Hz.
- `BaudRate`, 9600: line rate in baud.
- `clock`  input  1: system clock, 100 MHz / 10 ns; all logic on its rising edge.
- `reset`  input  1: one clock; reset is asynchronous and active-low (`reset` = 0 resets).
- `rx`  input  1: raw serial line, idle high, asynchronous to `clock`.
- `load`  output  1: one-cycle strobe; `data` holds a valid byte this cycle.
- `data`  output  B: last received byte; held until the next successful frame.
- `frame_error`  output  1: one-cycle strobe; stop bit sampled low.

## Operation
- Derived constants: `Divisor = ClockFreq / BaudRate` (integer truncation) and `Half = Divisor / 2`. `Divisor` < 4 is illegal; raise an elaboration error.
- `rx` passes through a 2-FF synchronizer. `rx_s` is the second stage, reset to 1.
- Bit timer: counter of width clog2(`Divisor`), cleared on every state entry. It counts `clock` cycles.
- FSM states and transitions:
  - `S_Idle`: if `rx_s` = 0, go to `S_Start`.
  - `S_Start`: when the counter reaches `Half`-1, sample `rx_s`. If 0, go to `S_Data` with bit index 0. If 1, treat it as a glitch and return to `S_Idle` with no strobe.
  - `S_Data`: every time the counter reaches `Divisor`-1, shift `rx_s` into the shift register at bit position index. After bit `B`-1 is taken, go to `S_Stop`.
  - `S_Stop`: at `Divisor`-1, sample `rx_s`.
    - If 1: copy the shift register to `data`, pulse `load` on the next cycle, then go to `S_Idle`.
    - If 0: pulse `frame_error` on the next cycle, leave `data` unchanged, then go to `S_Wait`.
  - `S_Wait`: stay until `rx_s` = 1, then go to `S_Idle`. This prevents a break condition from being decoded as a stream of 0x00 bytes.
- `load` and `frame_error` are registered and are never high in the same cycle.
- There is no back-pressure. The downstream stage must accept a byte on any strobe.

## Timing
- Reset values: `load` = 0, `frame_error` = 0, `data` = 0, state = `S_Idle`, both synchronizer stages = 1, bit counter and bit index = 0.
- Reset asserted mid-frame aborts the frame immediately with no strobe. The first frame after release whose start edge follows the release is received normally.
- Start edge to `rx_s` low: 2 cycles.
- Start-bit sample: `Half` cycles after `S_Start` entry.
- Data bit k sample: `Half` + (k+1)·`Divisor` cycles after `S_Start` entry.
- Stop sample: `Half` + (`B`+1)·`Divisor` cycles after `S_Start` entry.
- `load` / `frame_error` pulse: 1 cycle after the stop sample.
- The FSM is back in `S_Idle` ≈ `Divisor`/2 before the nominal end of the stop bit. A start bit that immediately follows a one-bit stop is therefore caught with full margin.
- Tolerates ±4 % combined baud mismatch at `B` = 8.

## Structure
- Shared header `gps_defs.vh`: `B`, `ClockFreq`, the GPS `BaudRate`, and the `S_*` state encodings. Encoding width is 3 bits, states 0–4.
- One natural sub-module, `bit_timer`. It contains the counter with a clear input and a `tick` output at a programmable terminal count (`Half`-1 or `Divisor`-1).
- The synchronizer stays inline.
- Keep a `state_str` debug register mirroring the state names.

## Test plan
Bench parameters: `ClockFreq` = 100, `BaudRate` = 10, giving `Divisor` = 10 and `Half` = 5.

- Send 0x24 ('$') with a clean 8N1 frame starting at cycle 20 → exactly one `load` with `data` = 0x24, asserted `Half` + 9·10 + 1 cycles after `S_Start` entry; `frame_error` stays 0.
- Drive `rx` low for 3 cycles, then high → FSM returns to `S_Idle` after the start sample; no strobe.
- Send "$G" (0x24, 0x47) back-to-back, each with a one-bit stop → two `load` pulses 100 cycles apart, carrying 0x24 then 0x47.
- Send 0x5A with the stop bit forced to 0, then hold `rx` low for 30 cycles → one `frame_error` pulse, no `load`, `data` keeps its previous value, FSM remains in `S_Wait` until `rx` rises; a following 0x41 is received correctly.
- Pull `reset` low during data bit 3 of a frame → all outputs are 0 within the same cycle, with no strobe; after release, a new 0x0D frame yields `load` with `data` = 0x0D.
- Send a 0xFF then a 0x00 frame with the baud period stretched to 10.4 cycles → both bytes are received correctly with no `frame_error`.
